// File: rtl/uart_cmd_bridge_if.sv
// Signal bundle between the command bridge, the uart byte core and the internal memory bus.
// master = bridge side, slave = uart core / bus fabric side.
interface uart_cmd_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              uart_received;
  logic [7:0]        uart_rx_byte;
  logic              uart_recv_error;
  logic              uart_transmit_n;
  logic [7:0]        uart_tx_byte;
  logic              uart_is_transmitting;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              busy;

  modport master (
    input  uart_received, uart_rx_byte, uart_recv_error, uart_is_transmitting,
    input  bus_ack, bus_rdata,
    output uart_transmit_n, uart_tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy
  );

  modport slave (
    output uart_received, uart_rx_byte, uart_recv_error, uart_is_transmitting,
    output bus_ack, bus_rdata,
    input  uart_transmit_n, uart_tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// Serial command decoder: 'W' addr data -> bus write, 'R' addr -> bus read, replies over uart tx.
// state       | meaning
// IDLE        | waiting for an opcode byte
// GET_ADDR    | shifting address bytes in, MSB first
// GET_DATA    | shifting write-data bytes in, MSB first
// BUS         | bus_req high, waiting for bus_ack or bus timeout
// SEND        | load next response byte and fire the 1-cycle tx strobe
// WAIT_BUSY   | waiting for the uart to report it has taken the byte
// WAIT_IDLE   | waiting for the uart to finish; then next byte or IDLE
module uart_cmd_bridge #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int RX_TIMEOUT  = 2000000,
  parameter int BUS_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  uart_cmd_bridge_if.master ifc
);
  localparam int ADDR_B = ADDR_W / 8;
  localparam int DATA_B = DATA_W / 8;
  localparam int CNT_W  = $clog2((ADDR_B > DATA_B ? ADDR_B : DATA_B) + 1);
  localparam int RSP_W  = $clog2(DATA_B + 1);
  localparam int RXT_W  = $clog2(RX_TIMEOUT + 1);
  localparam int BUST_W = $clog2(BUS_TIMEOUT + 1);

  localparam logic [RXT_W-1:0]  RXT_LOAD  = RXT_W'(RX_TIMEOUT - 1);
  localparam logic [BUST_W-1:0] BUST_LOAD = BUST_W'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_BUS, S_SEND, S_WAIT_BUSY, S_WAIT_IDLE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RXT_W-1:0]    rxt_q, rxt_d;
  logic [BUST_W-1:0]   bust_q, bust_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic [RSP_W-1:0]    rsp_cnt_q, rsp_cnt_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_n_q, tx_n_d;
  logic                rx_ok;

  // Single-byte responses sit MSB-aligned so SEND always takes the top byte.
  function automatic logic [DATA_W-1:0] one_byte(input logic [7:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    r[DATA_W-1 -: 8] = b;
    return r;
  endfunction

  assign rx_ok = ifc.uart_received && !ifc.uart_recv_error;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rxt_q     <= '0;
      bust_q    <= '0;
      rsp_q     <= '0;
      rsp_cnt_q <= '0;
      tx_byte_q <= '0;
      tx_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      rxt_q     <= rxt_d;
      bust_q    <= bust_d;
      rsp_q     <= rsp_d;
      rsp_cnt_q <= rsp_cnt_d;
      tx_byte_q <= tx_byte_d;
      tx_n_q    <= tx_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rxt_d     = rxt_q;
    bust_d    = bust_q;
    rsp_d     = rsp_q;
    rsp_cnt_d = rsp_cnt_q;
    tx_byte_d = tx_byte_q;
    tx_n_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (rx_ok) begin
          case (ifc.uart_rx_byte)
            8'h57, 8'h52: begin
              we_d    = (ifc.uart_rx_byte == 8'h57);
              cnt_d   = CNT_W'(ADDR_B);
              rxt_d   = RXT_LOAD;
              state_d = S_GET_ADDR;
            end
            default: begin
              rsp_d     = one_byte(8'h45);
              rsp_cnt_d = RSP_W'(1);
              state_d   = S_SEND;
            end
          endcase
        end
      end
      S_GET_ADDR, S_GET_DATA: begin
        if (ifc.uart_recv_error) begin
          state_d = S_IDLE;
        end else if (ifc.uart_received) begin
          rxt_d = RXT_LOAD;
          if (state_q == S_GET_ADDR) addr_d  = (addr_q << 8) | ADDR_W'(ifc.uart_rx_byte);
          else                       wdata_d = (wdata_q << 8) | DATA_W'(ifc.uart_rx_byte);
          if (cnt_q == CNT_W'(1)) begin
            if (state_q == S_GET_ADDR && we_q) begin
              cnt_d   = CNT_W'(DATA_B);
              state_d = S_GET_DATA;
            end else begin
              bust_d  = BUST_LOAD;
              state_d = S_BUS;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (rxt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          rxt_d = rxt_q - RXT_W'(1);
        end
      end
      S_BUS: begin
        if (ifc.bus_ack) begin
          rsp_d     = we_q ? one_byte(8'h4B) : ifc.bus_rdata;
          rsp_cnt_d = we_q ? RSP_W'(1) : RSP_W'(DATA_B);
          state_d   = S_SEND;
        end else if (bust_q == '0) begin
          rsp_d     = one_byte(8'h45);
          rsp_cnt_d = RSP_W'(1);
          state_d   = S_SEND;
        end else begin
          bust_d = bust_q - BUST_W'(1);
        end
      end
      S_SEND: begin
        tx_byte_d = rsp_q[DATA_W-1 -: 8];
        tx_n_d    = 1'b0;
        rsp_d     = rsp_q << 8;
        rsp_cnt_d = rsp_cnt_q - RSP_W'(1);
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (ifc.uart_is_transmitting) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (!ifc.uart_is_transmitting) state_d = (rsp_cnt_q != '0) ? S_SEND : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ifc.uart_transmit_n = tx_n_q;
  assign ifc.uart_tx_byte    = tx_byte_q;
  assign ifc.bus_req         = (state_q == S_BUS);
  assign ifc.bus_we          = we_q;
  assign ifc.bus_addr        = addr_q;
  assign ifc.bus_wdata       = wdata_q;
  assign ifc.busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: frame-level scoreboard of bus transfers and tx bytes,
// with a cycle monitor checking latencies, strobe width and byte stability.
module tb_uart_cmd_bridge;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int RXT = 40;
  localparam int BT  = 12;
  localparam int AB  = AW / 8;
  localparam int NB  = DW / 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  uart_cmd_bridge #(.ADDR_W(AW), .DATA_W(DW), .RX_TIMEOUT(RXT), .BUS_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .ifc(ifc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int strobes = 0;
  int req_rises = 0;
  int ack_delay = 0;
  logic [DW-1:0] rd_val = '0;
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  bus_t exp_bus[$];
  logic          last_we = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // uart tx core: busy for a few cycles after each start strobe
  initial forever begin
    @(negedge clk);
    if (rst_n && ifc.uart_transmit_n === 1'b0) begin
      @(posedge clk); #1 ifc.uart_is_transmitting = 1'b1;
      repeat (5) @(posedge clk);
      #1 ifc.uart_is_transmitting = 1'b0;
    end
  end

  // bus slave: ack ack_delay cycles after bus_req is first seen; never if ack_delay < 0
  initial forever begin
    @(negedge clk);
    if (rst_n && ifc.bus_req) begin
      if (ack_delay >= 0) begin
        repeat (ack_delay) @(posedge clk);
        #1 ifc.bus_ack = 1'b1; ifc.bus_rdata = rd_val;
        @(posedge clk); #1 ifc.bus_ack = 1'b0;
      end
      for (int k = 0; k < 100 && ifc.bus_req; k++) @(negedge clk);
    end
  end

  // cycle monitor against the scoreboard
  initial begin : monitor
    logic prev_req, prev_txn, acked, chk_lat, tx_valid;
    logic [7:0] cur_tx;
    int rise_cyc, ack_cyc;
    bus_t e;
    prev_req = 0; prev_txn = 1; acked = 0; chk_lat = 0; tx_valid = 0; cur_tx = 0;
    rise_cyc = 0; ack_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 0; prev_txn = 1; acked = 0; chk_lat = 0; tx_valid = 0;
      end else begin
        if (ifc.uart_transmit_n === 1'b0) begin
          strobes++;
          chk("strobe_one_cycle", 32'(prev_txn), 32'd1);
          if (chk_lat) begin
            chk("ack_to_strobe_latency", cyc - ack_cyc, 32'd2);
            chk_lat = 0;
          end
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx: got 0x%0h, expected no strobe (cycle %0d)", ifc.uart_tx_byte, cyc);
          end else begin
            chk("tx_byte", 32'(ifc.uart_tx_byte), 32'(exp_tx.pop_front()));
          end
          cur_tx = ifc.uart_tx_byte;
          tx_valid = 1;
          tx_log.push_back(ifc.uart_tx_byte);
        end else if (ifc.uart_is_transmitting && tx_valid) begin
          chk("tx_byte_stable", 32'(ifc.uart_tx_byte), 32'(cur_tx));
        end
        if (ifc.bus_req && !prev_req) begin
          req_rises++;
          rise_cyc = cyc;
          acked = 0;
          chk("rx_to_req_latency", cyc - last_rx_cyc, 32'd1);
          last_we = ifc.bus_we; last_addr = ifc.bus_addr; last_wdata = ifc.bus_wdata;
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bus_req: got addr 0x%0h, expected no request (cycle %0d)", ifc.bus_addr, cyc);
          end else begin
            e = exp_bus.pop_front();
            chk("bus_we", 32'(ifc.bus_we), 32'(e.we));
            chk("bus_addr", 32'(ifc.bus_addr), 32'(e.addr));
            if (e.we) chk("bus_wdata", ifc.bus_wdata, e.wdata);
          end
        end
        if (ifc.bus_req && ifc.bus_ack) begin
          acked = 1;
          ack_cyc = cyc;
        end
        if (!ifc.bus_req && prev_req) begin
          if (acked) begin
            chk("req_drop_after_ack", cyc - ack_cyc, 32'd1);
            chk_lat = 1;
          end else begin
            chk("req_timeout_length", cyc - rise_cyc, 32'(BT));
          end
        end
        prev_req = ifc.bus_req;
        prev_txn = ifc.uart_transmit_n;
      end
    end
  end

  // Frame-level model: what the bus must see and what must come back.
  task automatic expect_frame(input logic [7:0] f[$], input int ackd, input logic [DW-1:0] rd);
    bus_t b;
    b.we = 0; b.addr = '0; b.wdata = '0;
    if (f[0] == 8'h57 || f[0] == 8'h52) begin
      b.we = (f[0] == 8'h57);
      for (int i = 0; i < AB; i++) b.addr = (b.addr << 8) | AW'(f[1+i]);
      if (b.we) for (int i = 0; i < NB; i++) b.wdata = (b.wdata << 8) | DW'(f[1+AB+i]);
      exp_bus.push_back(b);
      if (ackd < 0)  exp_tx.push_back(8'h45);
      else if (b.we) exp_tx.push_back(8'h4B);
      else for (int i = NB - 1; i >= 0; i--) exp_tx.push_back(8'((rd >> (8 * i)) & 32'hFF));
    end else begin
      exp_tx.push_back(8'h45);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ifc.uart_received = 1'b1; ifc.uart_rx_byte = b; last_rx_cyc = cyc;
    @(posedge clk); #1;
    ifc.uart_received = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((ifc.busy || exp_tx.size() != 0) && k < 500);
    chk({name, "_idle_in_time"}, 32'(k < 500), 32'd1);
    chk({name, "_tx_drained"}, exp_tx.size(), 32'd0);
    chk({name, "_bus_drained"}, exp_bus.size(), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic run_frame(input string name, input logic [7:0] f[$], input int ackd, input logic [DW-1:0] rd);
    ack_delay = ackd;
    rd_val = rd;
    expect_frame(f, ackd, rd);
    foreach (f[i]) send_byte(f[i]);
    wait_idle(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] fr[$];
    int base, t, rises0, k;
    ifc.uart_received = 0; ifc.uart_rx_byte = 0; ifc.uart_recv_error = 0;
    ifc.uart_is_transmitting = 0; ifc.bus_ack = 0; ifc.bus_rdata = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_transmit_n", 32'(ifc.uart_transmit_n), 32'd1);
    chk("rst_tx_byte", 32'(ifc.uart_tx_byte), 32'd0);
    chk("rst_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("rst_bus_we", 32'(ifc.bus_we), 32'd0);
    chk("rst_bus_addr", 32'(ifc.bus_addr), 32'd0);
    chk("rst_bus_wdata", ifc.bus_wdata, 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // write
    tx_log.delete();
    fr = {8'h57, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("write", fr, 3, '0);
    chk("w_we", 32'(last_we), 32'd1);
    chk("w_addr", 32'(last_addr), 32'h1234);
    chk("w_wdata", last_wdata, 32'hDEADBEEF);
    chk("w_resp_count", tx_log.size(), 32'd1);
    if (tx_log.size() > 0) chk("w_resp", 32'(tx_log[0]), 32'h4B);

    // read
    tx_log.delete();
    fr = {8'h52, 8'h00, 8'h10};
    run_frame("read", fr, 2, 32'hCAFEF00D);
    chk("r_we", 32'(last_we), 32'd0);
    chk("r_addr", 32'(last_addr), 32'h0010);
    chk("r_resp_count", tx_log.size(), 32'd4);
    if (tx_log.size() == 4) begin
      chk("r_resp0", 32'(tx_log[0]), 32'hCA);
      chk("r_resp1", 32'(tx_log[1]), 32'hFE);
      chk("r_resp2", 32'(tx_log[2]), 32'hF0);
      chk("r_resp3", 32'(tx_log[3]), 32'h0D);
    end
    chk("wdata_held", ifc.bus_wdata, 32'hDEADBEEF);
    chk("addr_held", 32'(ifc.bus_addr), 32'h0010);

    // unknown opcode
    tx_log.delete();
    rises0 = req_rises;
    fr = {8'h41};
    run_frame("badop", fr, 0, '0);
    chk("badop_resp_count", tx_log.size(), 32'd1);
    if (tx_log.size() > 0) chk("badop_resp", 32'(tx_log[0]), 32'h45);
    chk("badop_no_bus", req_rises - rises0, 32'd0);
    chk("badop_busy_low", 32'(ifc.busy), 32'd0);

    // inter-byte timeout
    base = strobes; rises0 = req_rises;
    send_byte(8'h57);
    send_byte(8'h12);
    t = last_rx_cyc;
    while (cyc < t + RXT - 2) @(negedge clk);
    chk("rxto_still_busy", 32'(ifc.busy), 32'd1);
    while (cyc < t + RXT + 2) @(negedge clk);
    chk("rxto_idle", 32'(ifc.busy), 32'd0);
    chk("rxto_no_tx", strobes - base, 32'd0);
    chk("rxto_no_bus", req_rises - rises0, 32'd0);
    fr = {8'h52, 8'h00, 8'h00};
    run_frame("after_rxto", fr, 1, 32'h01020304);

    // framing error mid-frame, coincident with a received byte
    base = strobes; rises0 = req_rises;
    send_byte(8'h52);
    send_byte(8'h00);
    @(posedge clk); #1;
    ifc.uart_received = 1'b1; ifc.uart_rx_byte = 8'h11; ifc.uart_recv_error = 1'b1;
    @(posedge clk); #1;
    ifc.uart_received = 1'b0; ifc.uart_recv_error = 1'b0;
    @(negedge clk);
    chk("rxerr_abort", 32'(ifc.busy), 32'd0);
    @(posedge clk); #1 ifc.uart_recv_error = 1'b1;
    @(posedge clk); #1 ifc.uart_recv_error = 1'b0;
    @(negedge clk);
    chk("rxerr_idle_ignored", 32'(ifc.busy), 32'd0);
    repeat (5) @(posedge clk);
    chk("rxerr_no_tx", strobes - base, 32'd0);
    chk("rxerr_no_bus", req_rises - rises0, 32'd0);

    // bus timeout, with a stray byte arriving during the bus phase
    tx_log.delete();
    ack_delay = -1;
    fr = {8'h52, 8'h00, 8'h20};
    expect_frame(fr, -1, '0);
    foreach (fr[i]) send_byte(fr[i]);
    send_byte(8'h57);
    wait_idle("bus_timeout");
    chk("bto_addr", 32'(last_addr), 32'h0020);
    chk("bto_resp_count", tx_log.size(), 32'd1);
    if (tx_log.size() > 0) chk("bto_resp", 32'(tx_log[0]), 32'h45);

    // reset during the second byte of a read response
    ack_delay = 1;
    rd_val = 32'h11223344;
    fr = {8'h52, 8'h00, 8'h30};
    base = strobes;
    expect_frame(fr, 1, 32'h11223344);
    foreach (fr[i]) send_byte(fr[i]);
    k = 0;
    while (strobes < base + 2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("mid_send_second_strobe_seen", 32'(strobes >= base + 2), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_tx.delete();
    exp_bus.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mrst_transmit_n", 32'(ifc.uart_transmit_n), 32'd1);
    chk("mrst_tx_byte", 32'(ifc.uart_tx_byte), 32'd0);
    chk("mrst_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("mrst_bus_addr", 32'(ifc.bus_addr), 32'd0);
    chk("mrst_bus_wdata", ifc.bus_wdata, 32'd0);
    chk("mrst_busy", 32'(ifc.busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mrst_no_more_strobes", strobes - base, 32'd2);
    chk("mrst_still_idle", 32'(ifc.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
